// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank and its write-port arbiter.
package reg_bank_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = 8;

  // Requester indices as seen on last_grant
  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Valid/ready write-request channel from one writeback source to the arbiter.
interface reg_wr_req_if
  import reg_bank_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);

endinterface

// File: rtl/reg_write_arbiter_decoder.sv
// One-hot register enable decode with optional read-only register 0.
module reg_addr_decoder #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  // Writes to register 0 still decode as accepted upstream but produce no enable
  always_comb begin
    onehot = '0;
    if (en && !((ZERO_REG != 0) && (addr == '0)))
      onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between ALU and load writeback.
module reg_write_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = reg_bank_pkg::NUM_REGS,
  parameter int DATA_W   = reg_bank_pkg::DATA_W,
  parameter int ADDR_W   = reg_bank_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  reg_wr_req_if.slave         req0,
  reg_wr_req_if.slave         req1,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                last_grant,
  output cnt_t                conflict_cnt
);

  logic                both_valid;
  logic                grant_valid;
  logic                grant_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] dec_onehot;

  assign both_valid = req0.valid && req1.valid;

  // Contention goes to whichever side did not win last time
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = REQ_ALU;
    if (!rst && !stall) begin
      if (both_valid) begin
        grant_valid = 1'b1;
        grant_idx   = ~last_grant;
      end else if (req0.valid) begin
        grant_valid = 1'b1;
        grant_idx   = REQ_ALU;
      end else if (req1.valid) begin
        grant_valid = 1'b1;
        grant_idx   = REQ_LOAD;
      end
    end
  end

  assign req0.ready = grant_valid && (grant_idx == REQ_ALU);
  assign req1.ready = grant_valid && (grant_idx == REQ_LOAD);

  assign sel_addr = (grant_idx == REQ_LOAD) ? req1.addr : req0.addr;
  assign sel_data = (grant_idx == REQ_LOAD) ? req1.data : req0.data;

  reg_addr_decoder #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_dec (
    .en     (grant_valid),
    .addr   (sel_addr),
    .onehot (dec_onehot)
  );

  // last_grant resets to the load side so the ALU wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en        <= '0;
      wr_data      <= '0;
      last_grant   <= REQ_LOAD;
      conflict_cnt <= '0;
    end else begin
      wr_en <= dec_onehot;
      if (grant_valid) begin
        wr_data    <= sel_data;
        last_grant <= grant_idx;
      end
      if (both_valid && !stall && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter, with ZERO_REG on and off.
module tb_reg_write_arbiter;
  import reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        r0_valid, r1_valid;
  logic [2:0]  r0_addr, r1_addr;
  logic [31:0] r0_data, r1_data;

  logic [7:0]  wr_en_a, wr_en_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic        last_grant_a, last_grant_b;
  cnt_t        cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  reg_wr_req_if ia0 ();
  reg_wr_req_if ia1 ();
  reg_wr_req_if ib0 ();
  reg_wr_req_if ib1 ();

  assign ia0.valid = r0_valid;
  assign ia0.addr  = r0_addr;
  assign ia0.data  = r0_data;
  assign ia1.valid = r1_valid;
  assign ia1.addr  = r1_addr;
  assign ia1.data  = r1_data;
  assign ib0.valid = r0_valid;
  assign ib0.addr  = r0_addr;
  assign ib0.data  = r0_data;
  assign ib1.valid = r1_valid;
  assign ib1.addr  = r1_addr;
  assign ib1.data  = r1_data;

  always #5 clk = ~clk;

  reg_write_arbiter #(.ZERO_REG(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .req0         (ia0.slave),
    .req1         (ia1.slave),
    .wr_en        (wr_en_a),
    .wr_data      (wr_data_a),
    .last_grant   (last_grant_a),
    .conflict_cnt (cnt_a)
  );

  reg_write_arbiter #(.ZERO_REG(0)) dut_nz (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .req0         (ib0.slave),
    .req1         (ib1.slave),
    .wr_en        (wr_en_b),
    .wr_data      (wr_data_b),
    .last_grant   (last_grant_b),
    .conflict_cnt (cnt_b)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic        exp_g;
    logic [31:0] exp_data;

    rst = 1'b1; stall = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_data = '0; r1_data = '0;

    // Reset values, readies forced low while rst is high
    tick();
    r0_valid = 1'b1;
    #1;
    check_output("rst_ready0", {31'b0, ia0.ready}, 32'd0);
    tick();
    check_output("rst_wr_en", {24'b0, wr_en_a}, 32'd0);
    check_output("rst_wr_data", wr_data_a, 32'd0);
    check_output("rst_last_grant", {31'b0, last_grant_a}, 32'd1);
    check_output("rst_cnt", {24'b0, cnt_a}, 32'd0);
    r0_valid = 1'b0;
    rst = 1'b0;

    // Test 1: single req0 write to register 3
    r0_valid = 1'b1; r0_addr = 3'd3; r0_data = 32'hDEADBEEF;
    #1;
    check_output("t1_ready0", {31'b0, ia0.ready}, 32'd1);
    check_output("t1_ready1", {31'b0, ia1.ready}, 32'd0);
    tick();
    r0_valid = 1'b0;
    check_output("t1_wr_en", {24'b0, wr_en_a}, 32'h08);
    check_output("t1_wr_en_nz", {24'b0, wr_en_b}, 32'h08);
    check_output("t1_wr_data", wr_data_a, 32'hDEADBEEF);
    check_output("t1_last_grant", {31'b0, last_grant_a}, 32'd0);
    tick();
    check_output("t1_wr_en_idle", {24'b0, wr_en_a}, 32'd0);
    check_output("t1_wr_data_hold", wr_data_a, 32'hDEADBEEF);

    // Test 2: both valid for 4 cycles, alternating from req0
    do_reset();
    r0_valid = 1'b1; r0_addr = 3'd1; r0_data = 32'hA000_0000;
    r1_valid = 1'b1; r1_addr = 3'd2; r1_data = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      exp_g    = (i % 2 == 1);
      exp_data = exp_g ? r1_data : r0_data;
      #1;
      check_output($sformatf("t2_ready0_%0d", i), {31'b0, ia0.ready}, {31'b0, !exp_g});
      check_output($sformatf("t2_ready1_%0d", i), {31'b0, ia1.ready}, {31'b0, exp_g});
      tick();
      check_output($sformatf("t2_wr_en_%0d", i), {24'b0, wr_en_a}, exp_g ? 32'h04 : 32'h02);
      check_output($sformatf("t2_wr_data_%0d", i), wr_data_a, exp_data);
      check_output($sformatf("t2_last_grant_%0d", i), {31'b0, last_grant_a}, {31'b0, exp_g});
      check_output($sformatf("t2_cnt_%0d", i), {24'b0, cnt_a}, i + 1);
      if (exp_g) r1_data = r1_data + 1;
      else       r0_data = r0_data + 1;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Test 3: write to register 0 is accepted but suppressed only with ZERO_REG
    r0_valid = 1'b1; r0_addr = 3'd0; r0_data = 32'h1234;
    #1;
    check_output("t3_ready0", {31'b0, ia0.ready}, 32'd1);
    tick();
    r0_valid = 1'b0;
    check_output("t3_wr_en_zero", {24'b0, wr_en_a}, 32'd0);
    check_output("t3_wr_en_nz", {24'b0, wr_en_b}, 32'h01);
    check_output("t3_last_grant", {31'b0, last_grant_a}, 32'd0);

    // Test 4: stall blocks grants and counting
    stall = 1'b1;
    r0_valid = 1'b1; r0_addr = 3'd6; r0_data = 32'hC0C0_0000;
    r1_valid = 1'b1; r1_addr = 3'd7; r1_data = 32'hD0D0_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output($sformatf("t4_ready0_%0d", i), {31'b0, ia0.ready}, 32'd0);
      check_output($sformatf("t4_ready1_%0d", i), {31'b0, ia1.ready}, 32'd0);
      tick();
      check_output($sformatf("t4_wr_en_%0d", i), {24'b0, wr_en_a}, 32'd0);
      check_output($sformatf("t4_cnt_%0d", i), {24'b0, cnt_a}, 32'd4);
    end
    check_output("t4_last_grant_hold", {31'b0, last_grant_a}, 32'd0);
    stall = 1'b0;
    #1;
    check_output("t4_release_ready0", {31'b0, ia0.ready}, 32'd0);
    check_output("t4_release_ready1", {31'b0, ia1.ready}, 32'd1);
    tick();
    check_output("t4_release_wr_en", {24'b0, wr_en_a}, 32'h80);
    check_output("t4_release_data", wr_data_a, 32'hD0D0_0000);
    check_output("t4_release_cnt", {24'b0, cnt_a}, 32'd5);

    // Test 5: long contention saturates the counter
    for (int i = 0; i < 300; i++) tick();
    check_output("t5_cnt_sat", {24'b0, cnt_a}, 32'd255);
    tick();
    check_output("t5_cnt_hold", {24'b0, cnt_a}, 32'd255);
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();

    // Test 6: reset lands on a req1 transfer edge
    r0_valid = 1'b1; r0_addr = 3'd2; r0_data = 32'h1;
    tick();
    check_output("t6_pre_last_grant", {31'b0, last_grant_a}, 32'd0);
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_addr = 3'd5; r1_data = 32'h5555_5555;
    #1;
    check_output("t6_ready1", {31'b0, ia1.ready}, 32'd1);
    rst = 1'b1;
    #1;
    check_output("t6_ready1_rst", {31'b0, ia1.ready}, 32'd0);
    tick();
    check_output("t6_wr_en", {24'b0, wr_en_a}, 32'd0);
    check_output("t6_wr_data", wr_data_a, 32'd0);
    check_output("t6_last_grant", {31'b0, last_grant_a}, 32'd1);
    check_output("t6_cnt", {24'b0, cnt_a}, 32'd0);
    rst = 1'b0;
    r1_valid = 1'b0;
    tick();
    check_output("t6_no_pulse", {24'b0, wr_en_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
